// File: rtl/axis_pattern_generator.sv
// AXI4-Stream traffic source: emits bursts of patterned data (toggle, increment,
// Galois LFSR, walking-one) separated by a programmable idle interval.
module axis_pattern_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = 8'h01
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_interval,
  input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_bursts
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   interval_l;
  logic [LEN_WIDTH-1:0]   len_l;
  logic [LEN_WIDTH-1:0]   idx;
  logic [1:0]             mode_l;
  logic                   accept;
  logic                   last_beat;
  logic                   latch_cfg;

  function automatic logic [DATA_WIDTH-1:0] init_value(input logic [1:0] m);
    case (m)
      2'd2:    init_value = LFSR_SEED;
      2'd3:    init_value = DATA_WIDTH'(1);
      default: init_value = '0;
    endcase
  endfunction

  // Zero is a dead state for LFSR and walking-one, so those modes self-heal to init.
  function automatic logic [DATA_WIDTH-1:0] next_value(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] m);
    case (m)
      2'd0:    next_value = {{(DATA_WIDTH-1){1'b0}}, ~d[0]};
      2'd1:    next_value = d + DATA_WIDTH'(1);
      2'd2:    next_value = (d == '0) ? LFSR_SEED
                                      : ((d >> 1) ^ (d[0] ? LFSR_POLY : '0));
      default: next_value = (d == '0) ? DATA_WIDTH'(1)
                                      : {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
    endcase
  endfunction

  assign m_axis_tvalid = (state == S_SEND);
  assign last_beat     = (idx == len_l);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign accept        = m_axis_tvalid && m_axis_tready;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    latch_cfg = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_enable) begin
          state_n   = S_WAIT;
          latch_cfg = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == interval_l) state_n = S_SEND;
      end
      S_SEND: begin
        if (accept && last_beat) begin
          state_n   = cfg_enable ? S_WAIT : S_IDLE;
          latch_cfg = cfg_enable;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt          <= '0;
      interval_l   <= '0;
      len_l        <= '0;
      idx          <= '0;
      mode_l       <= 2'd0;
      m_axis_tdata <= '0;
      stat_beats   <= '0;
      stat_bursts  <= '0;
    end else begin
      if (latch_cfg) begin
        mode_l     <= cfg_mode;
        interval_l <= cfg_interval;
        len_l      <= cfg_burst_len;
        cnt        <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end

      if (accept) begin
        idx        <= last_beat ? '0 : idx + LEN_WIDTH'(1);
        stat_beats <= stat_beats + 32'd1;
        if (last_beat) stat_bursts <= stat_bursts + 32'd1;
      end

      // A mode switch at burst start overrides the update from the final beat.
      if (latch_cfg && (cfg_mode != mode_l))
        m_axis_tdata <= init_value(cfg_mode);
      else if (accept)
        m_axis_tdata <= next_value(m_axis_tdata, mode_l);
    end
  end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Directed bench for axis_pattern_generator: burst timing, patterns, backpressure,
// enable drop, mode switch and mid-burst reset.
module tb_axis_pattern_generator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_interval;
  logic [15:0] cfg_burst_len;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] stat_beats;
  logic [31:0] stat_bursts;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  axis_pattern_generator dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (cfg_enable),
    .cfg_mode      (cfg_mode),
    .cfg_interval  (cfg_interval),
    .cfg_burst_len (cfg_burst_len),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .stat_beats    (stat_beats),
    .stat_bursts   (stat_bursts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Ticks until tvalid is seen; returns the number of ticks taken (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_axis_tvalid && n < 2000);
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    cfg_enable = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast,  0);
    check("rst_tdata",  m_axis_tdata,  0);
    check("rst_busy",   busy,          0);
    check("rst_beats",  stat_beats,    0);
    check("rst_bursts", stat_bursts,   0);
  endtask

  initial begin
    int n;
    logic [7:0] model;
    int bad;
    areset        = 1'b1;
    cfg_enable    = 1'b0;
    cfg_mode      = 2'd0;
    cfg_interval  = 32'd0;
    cfg_burst_len = 16'd0;
    m_axis_tready = 1'b1;

    // Test 1: toggle, single-beat bursts every 5 cycles
    do_reset();
    cfg_mode = 2'd0; cfg_interval = 32'd3; cfg_burst_len = 16'd0; cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      check("t1_period", n, 5);
      check("t1_tdata", m_axis_tdata, i % 2);
      check("t1_tlast", m_axis_tlast, 1);
      if (i == 3) cfg_enable = 1'b0;
    end
    tick();
    check("t1_bursts", stat_bursts, 4);
    check("t1_beats",  stat_beats,  4);
    check("t1_busy",   busy,        0);

    // Test 2: increment, 4-beat bursts with interval 0
    do_reset();
    cfg_mode = 2'd1; cfg_interval = 32'd0; cfg_burst_len = 16'd3; cfg_enable = 1'b1;
    wait_valid(n);
    check("t2_latency", n, 2);
    for (int i = 0; i < 8; i++) begin
      check("t2_tvalid", m_axis_tvalid, 1);
      check("t2_tdata",  m_axis_tdata,  i);
      check("t2_tlast",  m_axis_tlast,  (i % 4) == 3);
      if (i == 7) cfg_enable = 1'b0;
      tick();
      if (i == 3) begin
        check("t2_gap", m_axis_tvalid, 0);
        tick();
      end
    end
    check("t2_bursts", stat_bursts, 2);
    check("t2_beats",  stat_beats,  8);
    check("t2_busy",   busy,        0);

    // Test 3: backpressure mid-burst
    do_reset();
    cfg_mode = 2'd1; cfg_interval = 32'd0; cfg_burst_len = 16'd2; cfg_enable = 1'b1;
    wait_valid(n);
    check("t3_b0", m_axis_tdata, 0);
    tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", m_axis_tvalid, 1);
      check("t3_hold_data",  m_axis_tdata,  1);
      check("t3_hold_last",  m_axis_tlast,  0);
    end
    m_axis_tready = 1'b1;
    tick();
    check("t3_b2", m_axis_tdata, 2);
    check("t3_b2_last", m_axis_tlast, 1);
    cfg_enable = 1'b0;
    tick();
    check("t3_beats", stat_beats, 3);
    check("t3_busy",  busy,       0);

    // Test 4: LFSR sequence and period
    do_reset();
    cfg_mode = 2'd2; cfg_interval = 32'd0; cfg_burst_len = 16'd254; cfg_enable = 1'b1;
    wait_valid(n);
    model = 8'h01;
    bad   = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == 0) check("t4_d0", m_axis_tdata, 8'h01);
      if (i == 1) check("t4_d1", m_axis_tdata, 8'hB8);
      if (i == 2) check("t4_d2", m_axis_tdata, 8'h5C);
      if (i == 3) check("t4_d3", m_axis_tdata, 8'h2E);
      if (m_axis_tdata !== model || m_axis_tdata == 8'h00 || !m_axis_tvalid) bad++;
      model = (model >> 1) ^ (model[0] ? 8'hB8 : 8'h00);
      if (i == 254) cfg_enable = 1'b0;
      tick();
    end
    check("t4_seq_errors", bad, 0);
    check("t4_wrap", m_axis_tdata, 8'h01);
    check("t4_bursts", stat_bursts, 1);

    // Test 5: enable drop mid-burst, then walking-one after mode switch
    do_reset();
    cfg_mode = 2'd1; cfg_interval = 32'd1; cfg_burst_len = 16'd3; cfg_enable = 1'b1;
    wait_valid(n);
    check("t5_latency", n, 3);
    tick();
    cfg_enable = 1'b0;
    tick();
    tick();
    check("t5_last", m_axis_tlast, 1);
    check("t5_d3",   m_axis_tdata, 3);
    tick();
    check("t5_idle_busy", busy,        0);
    check("t5_bursts",    stat_bursts, 1);
    cfg_mode = 2'd3; cfg_interval = 32'd0; cfg_burst_len = 16'd8; cfg_enable = 1'b1;
    wait_valid(n);
    for (int i = 0; i < 9; i++) begin
      check("t5_walk", m_axis_tdata, (i == 8) ? 32'h01 : (32'h1 << i));
      if (i == 8) begin
        check("t5_walk_last", m_axis_tlast, 1);
        cfg_enable = 1'b0;
      end
      tick();
    end
    check("t5_beats", stat_beats, 13);

    // Test 6: reset mid-SEND
    do_reset();
    cfg_mode = 2'd1; cfg_interval = 32'd0; cfg_burst_len = 16'd5; cfg_enable = 1'b1;
    wait_valid(n);
    tick();
    tick();
    check("t6_pre_beats", stat_beats, 2);
    areset = 1'b1;
    tick();
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_tdata",  m_axis_tdata,  0);
    check("t6_beats",  stat_beats,    0);
    check("t6_bursts", stat_bursts,   0);
    check("t6_busy",   busy,          0);
    areset     = 1'b0;
    cfg_enable = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
